btn_debounce_pulse: RTL and testbench

Upstream conditioning stage for the push-button counters on the board.
- Input: raw, bouncing, asynchronous push-button.
- Synchronises the input to clk and qualifies it with a stable-time counter and a 4-state FSM.
- Outputs: a clean level plus single-cycle press/release strobes.
- btn_press is the clean edge source that drives the downstream counter's clock or enable input.

---
 rtl/btn_debounce_pulse.sv | 119 +++++++++++
 tb/tb_btn_debounce_pulse.sv | 135 +++++++++++++
 2 files changed

// File: rtl/btn_debounce_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_pulse
//  Description : Push-button conditioner. Synchronises a raw, bouncing button
//                to clk, qualifies every level change with a stable-time
//                counter, and emits a clean level plus one-cycle press and
//                release strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_pulse #(
    parameter int STABLE_CYCLES = 1000000,  // consecutive samples to accept a change
    parameter int CNT_W         = 20        // 2**CNT_W must be >= STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,        // synchronous, active-low
    input  logic btnd,         // raw asynchronous button, active-high
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    // Terminal count: the sample that completes qualification.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             cnt_done;

    // Two-flop synchroniser; only sync2_q is visible to the qualifier.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btnd;
            sync2_q <= sync1_q;
        end
    end

    // Qualification is complete when the counter sits on its last value.
    assign cnt_done = (cnt_q == CNT_LAST);

    // Qualifier FSM with registered level and single-cycle strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            // Strobes fall back to zero unless a transition below sets them.
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sync2_q) begin
                        state_q <= ST_PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!sync2_q) begin
                        // Bounce: restart from scratch, nothing reported.
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_done) begin
                        state_q <= ST_PRESSED;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!sync2_q) begin
                        state_q <= ST_RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (sync2_q) begin
                        // Release glitch: the button is still considered held.
                        state_q <= ST_PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_done) begin
                        state_q   <= ST_IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debounce_pulse
//  Description : Directed self-checking bench for btn_debounce_pulse with
//                STABLE_CYCLES=4. Expected outputs are hand-derived edge
//                numbers: a level change first sampled at edge e0 is
//                reported after edge e0+6.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debounce_pulse;

    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 3;
    localparam int LAT           = STABLE_CYCLES + 2;

    logic clk = 1'b0;
    logic reset;
    logic btnd;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    int vectors     = 0;
    int miscompares = 0;

    btn_debounce_pulse #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btnd        (btnd),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    // Compare {level, press, release} against the expected triple.
    task automatic check_vec(input string tag, input logic [2:0] got, input logic [2:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: lvl/prs/rel got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 ns later and check.
    task automatic step(input string tag, input logic b, input logic r, input logic [2:0] exp);
        btnd  = b;
        reset = r;
        @(posedge clk);
        #1;
        check_vec(tag, {btn_level, btn_press, btn_release}, exp);
    endtask

    // Hold btnd at b (reset inactive); the change is first sampled at k=0.
    // For a press the level rises and press strobes at k=LAT; for a release
    // the level falls and release strobes at k=LAT.
    task automatic settle(input string tag, input logic b, input int n);
        logic [2:0] e;
        for (int k = 0; k < n; k++) begin
            if (b) e = {(k >= LAT), (k == LAT), 1'b0};
            else   e = {(k <  LAT), 1'b0, (k == LAT)};
            step($sformatf("%s[%0d]", tag, k), b, 1'b1, e);
        end
    endtask

    initial begin
        bit [0:6] p3;
        bit [0:3] p4;
        bit [0:3] p5;
        logic [2:0] e;

        reset = 1'b0;
        btnd  = 1'b0;

        // 1. Reset held with button pressed: everything stays quiet.
        for (int k = 0; k < 3; k++)
            step($sformatf("rst_hold[%0d]", k), 1'b1, 1'b0, 3'b000);
        // Release reset with button still high: full-latency press.
        settle("rst_rel_press", 1'b1, 10);
        settle("rst_rel_release", 1'b0, 10);

        // 2. Clean press held 20 cycles: single strobe, no auto-repeat.
        settle("clean_press", 1'b1, 20);
        settle("clean_release", 1'b0, 10);

        // 3. Bounces never reach four stable samples: nothing accepted.
        p3 = 7'b1101110;
        for (int k = 0; k < 7; k++)
            step($sformatf("bounce[%0d]", k), p3[k], 1'b1, 3'b000);
        for (int k = 0; k < 10; k++)
            step($sformatf("bounce_tail[%0d]", k), 1'b0, 1'b1, 3'b000);

        // 4. Bounce then settle high: final held 1 first sampled at index 4.
        p4 = 4'b1010;
        for (int k = 0; k < 4; k++)
            step($sformatf("settle_bnc[%0d]", k), p4[k], 1'b1, 3'b000);
        for (int k = 4; k < 20; k++) begin
            e = {(k >= 4 + LAT), (k == 4 + LAT), 1'b0};
            step($sformatf("settle_hold[%0d]", k), 1'b1, 1'b1, e);
        end

        // 5. Release with glitch from PRESSED: final held 0 starts at index 3.
        p5 = 4'b0010;
        for (int k = 0; k < 4; k++)
            step($sformatf("rel_bnc[%0d]", k), p5[k], 1'b1, 3'b100);
        for (int k = 4; k < 16; k++) begin
            e = {(k < 3 + LAT), 1'b0, (k == 3 + LAT)};
            step($sformatf("rel_hold[%0d]", k), 1'b0, 1'b1, e);
        end

        // 6. Reset while qualifying (counter at 2 after k=4), then re-qualify.
        for (int k = 0; k < 5; k++)
            step($sformatf("midq_pre[%0d]", k), 1'b1, 1'b1, 3'b000);
        for (int k = 0; k < 2; k++)
            step($sformatf("midq_rst[%0d]", k), 1'b1, 1'b0, 3'b000);
        settle("midq_requal", 1'b1, 10);
        settle("midq_release", 1'b0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute runtime guard.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire
